// File: rtl/framebuffer_readback_if.sv
// Byte-wide framebuffer read port shared between the readback engine and the RAM.
interface framebuffer_readback_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_clk_enable;
  logic [7:0]            ram_data_in;

  modport master (output ram_address, output ram_clk_enable, input ram_data_in);
  modport slave  (input ram_address, input ram_clk_enable, output ram_data_in);
endinterface

// File: rtl/framebuffer_readback.sv
// Streams header, framebuffer bytes and an 8-bit checksum out over an 8N1 UART.
// state    | meaning
// IDLE     | line high, waiting for start
// HEADER   | sending HEADER_BYTE
// DATA     | sending a prefetched framebuffer byte
// CHECKSUM | sending the 8-bit sum of all data bytes
module framebuffer_readback #(
  parameter int         UART_CLK_TICKS_PER_BIT = 65,
  parameter int         UART_CLK_TICKS_WIDTH   = 7,
  parameter int         ADDR_WIDTH             = 12,
  parameter int         BYTE_COUNT             = 4096,
  parameter logic [7:0] HEADER_BYTE            = 8'h44
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   start,
  framebuffer_readback_if.master ram,
  output logic                   tx_out,
  output logic                   busy,
  output logic                   done
);
  localparam int TW = UART_CLK_TICKS_WIDTH;
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(UART_CLK_TICKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BYTE_COUNT);
  localparam logic [3:0]    BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]    BIT_STOP      = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_CHECKSUM} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [3:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            hold_q, hold_d;
  logic [7:0]            csum_q, csum_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  rd_en_q, rd_en_d;
  logic                  rd_dly_q, rd_dly_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      csum_q    <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_dly_q  <= 1'b0;
      addr_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      rd_en_q   <= rd_en_d;
      rd_dly_q  <= rd_dly_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    rd_en_d   = 1'b0;
    rd_dly_d  = rd_en_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // RAM data is valid one clock after the strobe; capture it the clock after that.
    if (rd_dly_q) begin
      hold_d    = ram.ram_data_in;
      csum_d    = csum_q + ram.ram_data_in;
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_HEADER;
          shift_d   = HEADER_BYTE;
          csum_d    = '0;
          idx_d     = '0;
          pending_d = 1'b0;
          tick_d    = TICK_LOAD;
          bit_d     = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      default: begin
        if (tick_q != '0) begin
          tick_d = tick_q - TW'(1);
        end else begin
          tick_d = TICK_LOAD;
          if (bit_q != BIT_STOP) begin
            bit_d = bit_q + 4'd1;
            if (bit_q == BIT_LAST_DATA) begin
              tx_d = 1'b1;
              if (state_q != S_CHECKSUM && idx_q < IDX_LAST) begin
                rd_en_d = 1'b1;
                addr_d  = idx_q[ADDR_WIDTH-1:0];
                idx_d   = idx_q + IW'(1);
              end
            end else begin
              tx_d = shift_q[bit_q[2:0]];
            end
          end else if (state_q == S_CHECKSUM) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // a byte prefetched during this stop bit means more data follows
            bit_d     = '0;
            tx_d      = 1'b0;
            pending_d = 1'b0;
            if (pending_q) begin
              state_d = S_DATA;
              shift_d = hold_q;
            end else begin
              state_d = S_CHECKSUM;
              shift_d = csum_q;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    tx_out             = tx_q;
    busy               = busy_q;
    done               = done_q;
    ram.ram_address    = addr_q;
    ram.ram_clk_enable = rd_en_q;
  end
endmodule

// File: tb/tb_framebuffer_readback.sv
// Scoreboard bench: stimulus queues expected UART bytes, monitors decode tx and compare.
module tb_framebuffer_readback;
  logic clk_in = 1'b0;
  logic rst_n;
  logic start_s, start_f;
  logic tx_s, busy_s, done_s;
  logic tx_f, busy_f, done_f;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt[2] = '{0, 0};
  logic [8:0] q_s[$];
  logic [8:0] q_f[$];
  logic [7:0] mem_s[4];

  framebuffer_readback_if #(.ADDR_WIDTH(12)) bus_s ();
  framebuffer_readback_if #(.ADDR_WIDTH(10)) bus_f ();

  always #5 clk_in = ~clk_in;

  framebuffer_readback #(.UART_CLK_TICKS_PER_BIT(4), .ADDR_WIDTH(12), .BYTE_COUNT(4)) dut_s (
    .clk_in(clk_in), .reset(rst_n), .start(start_s), .ram(bus_s),
    .tx_out(tx_s), .busy(busy_s), .done(done_s));

  framebuffer_readback #(.UART_CLK_TICKS_PER_BIT(4), .ADDR_WIDTH(10), .BYTE_COUNT(1024)) dut_f (
    .clk_in(clk_in), .reset(rst_n), .start(start_f), .ram(bus_f),
    .tx_out(tx_f), .busy(busy_f), .done(done_f));

  always @(posedge clk_in) begin
    if (!rst_n) bus_s.ram_data_in <= 8'($urandom);
    else if (bus_s.ram_clk_enable) bus_s.ram_data_in <= mem_s[bus_s.ram_address[1:0]];
  end
  always @(posedge clk_in) begin
    if (!rst_n) bus_f.ram_data_in <= 8'($urandom);
    else if (bus_f.ram_clk_enable) bus_f.ram_data_in <= 8'hFF;
  end

  function automatic logic get_tx(input int sel);   return sel != 0 ? tx_f : tx_s;     endfunction
  function automatic logic get_busy(input int sel); return sel != 0 ? busy_f : busy_s; endfunction
  function automatic logic get_done(input int sel); return sel != 0 ? done_f : done_s; endfunction
  function automatic logic get_en(input int sel);
    return sel != 0 ? bus_f.ram_clk_enable : bus_s.ram_clk_enable;
  endfunction
  function automatic int get_addr(input int sel);
    return sel != 0 ? int'(bus_f.ram_address) : int'(bus_s.ram_address);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flush(input int sel);
    if (sel != 0) q_f.delete(); else q_s.delete();
  endtask

  task automatic uart_monitor(input int sel);
    logic       s[40];
    logic [7:0] b;
    logic [8:0] e;
    bit         ok, aborted, have_exp;
    bit         gap_pending = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        flush(sel);
        gap_pending = 1'b0;
        continue;
      end
      if (gap_pending) begin
        check("char_gap", int'(get_tx(sel)), 0);
        gap_pending = 1'b0;
      end
      if (get_tx(sel) === 1'b0) begin
        s[0] = 1'b0;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk_in);
          if (!rst_n) begin aborted = 1'b1; break; end
          s[i] = get_tx(sel);
        end
        if (aborted) begin flush(sel); continue; end
        ok = (s[0] == 1'b0) && (s[36] == 1'b1);
        for (int j = 0; j < 10; j++)
          for (int k = 1; k < 4; k++)
            if (s[4*j+k] !== s[4*j]) ok = 1'b0;
        for (int j = 0; j < 8; j++) b[j] = s[4*(j+1)];
        check("char_timing", int'(ok), 1);
        have_exp = (sel != 0) ? (q_f.size() > 0) : (q_s.size() > 0);
        if (!have_exp) begin
          checks++; errors++;
          $display("FAIL unexpected_char actual=%0h expected=none", b);
        end else begin
          e = (sel != 0) ? q_f.pop_front() : q_s.pop_front();
          check(sel != 0 ? "byte_f" : "byte_s", int'(b), int'(e[7:0]));
          gap_pending = !e[8];
        end
      end
    end
  endtask

  task automatic busy_monitor(input int sel, input int len);
    int cnt = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) cnt = 0;
      else begin
        if (get_done(sel)) done_cnt[sel]++;
        if (get_busy(sel)) cnt++;
        else if (cnt != 0) begin
          check("busy_len", cnt, len);
          check("done_pos", int'(get_done(sel)), 1);
          cnt = 0;
        end else if (get_done(sel)) begin
          checks++; errors++;
          $display("FAIL done_stray actual=1 expected=0");
        end
      end
    end
  endtask

  task automatic strobe_monitor(input int sel, input int n);
    int a = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) a = 0;
      else begin
        if (get_en(sel)) begin
          check("strobe_addr", get_addr(sel), a);
          a++;
        end
        if (get_done(sel)) begin
          check("read_count", a, n);
          a = 0;
        end
      end
    end
  endtask

  initial uart_monitor(0);
  initial uart_monitor(1);
  initial busy_monitor(0, 240);
  initial busy_monitor(1, 1026 * 40);
  initial strobe_monitor(0, 4);
  initial strobe_monitor(1, 1024);

  task automatic push_frame_s();
    logic [7:0] f[6];
    f = '{8'h44, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h05};
    for (int i = 0; i < 6; i++) q_s.push_back({(i == 5) ? 1'b1 : 1'b0, f[i]});
  endtask

  task automatic wait_done(input int sel, input int budget, input string name);
    checks++;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (get_done(sel)) return;
    end
    errors++;
    $display("FAIL %s timeout actual=no_done expected=done within %0d clocks", name, budget);
  endtask

  task automatic pulse_start_s();
    start_s = 1'b1;
    @(negedge clk_in);
    start_s = 1'b0;
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_tx"},   int'(get_tx(sel)), 1);
    check({tag, "_busy"}, int'(get_busy(sel)), 0);
    check({tag, "_done"}, int'(get_done(sel)), 0);
    check({tag, "_en"},   int'(get_en(sel)), 0);
  endtask

  int d0;

  initial begin
    mem_s = '{8'h01, 8'h02, 8'h03, 8'hFF};
    rst_n = 1'b1;
    start_s = 1'($urandom);
    start_f = 1'($urandom);
    #1 rst_n = 1'b0;

    // reset values with random start
    repeat (3) begin
      @(negedge clk_in);
      start_s = 1'($urandom);
      start_f = 1'($urandom);
    end
    check_idle(0, "rst_s");
    check_idle(1, "rst_f");
    check("rst_addr", get_addr(0), 0);
    start_s = 1'b0;
    start_f = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(negedge clk_in);
    check_idle(0, "post_rst_s");
    check_idle(1, "post_rst_f");

    // short frame and start latency
    push_frame_s();
    pulse_start_s();
    check("start_latency_tx", int'(tx_s), 0);
    check("start_latency_busy", int'(busy_s), 1);
    wait_done(0, 300, "short_frame");
    repeat (5) @(negedge clk_in);

    // start pulsed again mid-frame is ignored
    d0 = done_cnt[0];
    push_frame_s();
    pulse_start_s();
    repeat (100) @(negedge clk_in);
    pulse_start_s();
    wait_done(0, 300, "start_while_busy");
    repeat (20) @(negedge clk_in);
    check("single_done", done_cnt[0] - d0, 1);
    check("idle_after_frame", int'(busy_s), 0);

    // reset during the third byte
    push_frame_s();
    pulse_start_s();
    repeat (90) @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx_s), 1);
    check("midrst_busy", int'(busy_s), 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    push_frame_s();
    pulse_start_s();
    wait_done(0, 300, "after_reset_frame");
    repeat (5) @(negedge clk_in);

    // back-to-back frames with start held high
    d0 = done_cnt[0];
    push_frame_s();
    push_frame_s();
    start_s = 1'b1;
    wait_done(0, 300, "b2b_first");
    @(negedge clk_in);
    check("b2b_start_tx", int'(tx_s), 0);
    check("b2b_start_busy", int'(busy_s), 1);
    start_s = 1'b0;
    wait_done(0, 300, "b2b_second");
    repeat (20) @(negedge clk_in);
    check("b2b_done_count", done_cnt[0] - d0, 2);

    // full address range, RAM all FF, checksum 00
    q_f.push_back({1'b0, 8'h44});
    for (int i = 0; i < 1024; i++) q_f.push_back({1'b0, 8'hFF});
    q_f.push_back({1'b1, 8'h00});
    start_f = 1'b1;
    @(negedge clk_in);
    start_f = 1'b0;
    wait_done(1, 45000, "full_frame");
    repeat (20) @(negedge clk_in);
    check("full_done_count", done_cnt[1], 1);

    check("leftover_s", q_s.size(), 0);
    check("leftover_f", q_f.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
